// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared FSM state encoding and bus constants for the I2C slave
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_PTR,
        PTR_ACK,
        RX_DATA,
        DATA_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } i2c_state_t;

    localparam logic       I2C_RW_READ  = 1'b1;
    localparam logic [3:0] BIT_CNT_LAST = 4'd7;
    localparam logic [3:0] BIT_CNT_BYTE = 4'd8;

endpackage

// File: rtl/i2c_bus_cond_det.sv
// rtl/i2c_bus_cond_det.sv - SCL/SDA synchronizer with edge and START/STOP detection
//
// Ports:
//   clk, rst_n      sampling clock, asynchronous active-low reset
//   scl_in, sda_in  raw bus levels
//   sda             synchronized SDA level
//   scl_rise/fall   one-cycle pulses on synchronized SCL edges
//   start/stop      one-cycle pulses for SDA fall/rise while SCL is high
module i2c_bus_cond_det (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;
    logic       sda_q;
    logic       scl;

    // Idle bus is pulled high, so reset to 1 to avoid false edges on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
        end
    end

    assign scl      = scl_sync[1];
    assign sda      = sda_sync[1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    // SCL must be high in both samples so an SDA change right after an SCL fall
    // is never mistaken for a bus condition.
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_slave_mem.sv
// rtl/i2c_slave_mem.sv - byte-addressed I2C slave with internal register memory
//
// Ports:
//   pclk_i, preset_n_i    sampling clock, asynchronous active-low reset
//   scl_io                I2C clock, observed only
//   sda_io                I2C data, open drain (0 or z)
//   busy_o                addressed transfer in progress
//   wr_strobe_o           one-cycle pulse per data byte written, with wr_addr_o/wr_data_o
//   dbg_addr_i/dbg_data_o combinational memory read port
module i2c_slave_mem
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h10,
    parameter int         MEM_DEPTH  = 16,
    parameter int         PTR_W      = 4
) (
    input  logic             pclk_i,
    input  logic             preset_n_i,
    inout  wire              scl_io,
    inout  wire              sda_io,
    output logic             busy_o,
    output logic             wr_strobe_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o,
    input  logic [PTR_W-1:0] dbg_addr_i,
    output logic [7:0]       dbg_data_o
);

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_bus_cond_det u_cond_det (
        .clk      (pclk_i),
        .rst_n    (preset_n_i),
        .scl_in   (scl_io),
        .sda_in   (sda_io),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    i2c_state_t       state, state_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift, shift_n;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic             sda_oe, sda_oe_n;
    logic             busy_n;
    logic             rw, rw_n;
    logic             mem_we;
    logic [7:0]       mem [MEM_DEPTH];
    logic [7:0]       rx_byte;
    logic [7:0]       tx_byte;

    assign rx_byte    = {shift[6:0], sda};
    assign tx_byte    = mem[ptr];
    assign dbg_data_o = mem[dbg_addr_i];
    assign sda_io     = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            ptr         <= '0;
            sda_oe      <= 1'b0;
            busy_o      <= 1'b0;
            rw          <= 1'b0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            ptr         <= ptr_n;
            sda_oe      <= sda_oe_n;
            busy_o      <= busy_n;
            rw          <= rw_n;
            wr_strobe_o <= mem_we;
            if (mem_we) begin
                mem[ptr]  <= rx_byte;
                wr_addr_o <= ptr;
                wr_data_o <= rx_byte;
            end
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        ptr_n     = ptr;
        sda_oe_n  = sda_oe;
        busy_n    = busy_o;
        rw_n      = rw;
        mem_we    = 1'b0;
        if (stop) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (start) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ADDR, RX_PTR, RX_DATA: begin
                    if (scl_rise) begin
                        shift_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == BIT_CNT_LAST) begin
                            if (state == ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    busy_n  = 1'b1;
                                    rw_n    = rx_byte[0];
                                    state_n = ADDR_ACK;
                                end else begin
                                    state_n = WAIT_STOP;
                                end
                            end else if (state == RX_PTR) begin
                                ptr_n   = rx_byte[PTR_W-1:0];
                                state_n = PTR_ACK;
                            end else begin
                                mem_we  = 1'b1;
                                ptr_n   = ptr + PTR_W'(1);
                                state_n = DATA_ACK;
                            end
                        end
                    end
                end
                // sda_oe doubles as the phase flag: the first fall starts the
                // ACK, the second fall ends it.
                ADDR_ACK, PTR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            bit_cnt_n = '0;
                            if (state == ADDR_ACK && rw == I2C_RW_READ) begin
                                shift_n  = tx_byte;
                                sda_oe_n = ~tx_byte[7];
                                ptr_n    = ptr + PTR_W'(1);
                                state_n  = TX_BYTE;
                            end else begin
                                sda_oe_n = 1'b0;
                                state_n  = (state == ADDR_ACK) ? RX_PTR : RX_DATA;
                            end
                        end
                    end
                end
                TX_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == BIT_CNT_BYTE) begin
                            sda_oe_n = 1'b0;
                            state_n  = TX_ACK;
                        end else begin
                            shift_n  = {shift[6:0], 1'b0};
                            sda_oe_n = ~shift[6];
                        end
                    end
                end
                // Entered with bit_cnt == 8; cleared to 0 once the master ACKs,
                // which arms the reload on the closing SCL fall.
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda) begin
                            busy_n  = 1'b0;
                            state_n = WAIT_STOP;
                        end else begin
                            bit_cnt_n = '0;
                        end
                    end else if (scl_fall && bit_cnt == '0) begin
                        shift_n  = tx_byte;
                        sda_oe_n = ~tx_byte[7];
                        ptr_n    = ptr + PTR_W'(1);
                        state_n  = TX_BYTE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// tb/tb_i2c_slave_mem.sv - self-checking bench for i2c_slave_mem with bit-level master BFM
module tb_i2c_slave_mem;

    localparam int Q = 16;

    logic       pclk_i = 1'b0;
    logic       preset_n_i = 1'b1;
    wire        scl_io;
    wire        sda_io;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       busy_o, wr_strobe_o;
    logic [3:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic [3:0] dbg_addr_i = 4'd0;
    logic [7:0] dbg_data_o;

    pullup (scl_io);
    pullup (sda_io);
    assign scl_io = scl_m ? 1'bz : 1'b0;
    assign sda_io = sda_m ? 1'bz : 1'b0;

    always #1 pclk_i = ~pclk_i;

    i2c_slave_mem dut (
        .pclk_i      (pclk_i),
        .preset_n_i  (preset_n_i),
        .scl_io      (scl_io),
        .sda_io      (sda_io),
        .busy_o      (busy_o),
        .wr_strobe_o (wr_strobe_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_data_o  (dbg_data_o)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] model_mem [16];
    logic [3:0] model_ptr = 4'd0;
    logic [11:0] strobes [$];

    always @(negedge pclk_i) begin
        if (preset_n_i && wr_strobe_o) strobes.push_back({wr_addr_o, wr_data_o});
    end

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b; #Q;
        scl_m = 1'b1; #Q;
        r = sda_io; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            b[i] = r;
        end
        bit_xfer(~ack, r);
    endtask

    task automatic dbg_read(input logic [3:0] a, output logic [7:0] d);
        dbg_addr_i = a; #2;
        d = dbg_data_o;
    endtask

    // Full write transaction; returns the number of ACKs the slave gave.
    task automatic bus_write(input logic [7:0] pb, input logic [7:0] d [$], output int acks);
        logic a;
        acks = 0;
        i2c_start();
        send_byte(8'h20, a); acks += int'(a);
        send_byte(pb, a);    acks += int'(a);
        foreach (d[i]) begin
            send_byte(d[i], a); acks += int'(a);
        end
        i2c_stop();
    endtask

    task automatic model_write(input logic [7:0] pb, input logic [7:0] d [$]);
        model_ptr = pb[3:0];
        foreach (d[i]) begin
            model_mem[model_ptr] = d[i];
            model_ptr = model_ptr + 4'd1;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        preset_n_i = 1'b1; #2;
        preset_n_i = 1'b0; #10;
        preset_n_i = 1'b1; #4;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        model_ptr = 4'd0;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        n_checks++; if (wr_strobe_o !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %b exp 0", wr_strobe_o); end
        n_checks++; if (wr_addr_o !== 4'd0 || wr_data_o !== 8'd0) begin n_fail++; $display("FAIL reset_wr got %h/%h exp 0/00", wr_addr_o, wr_data_o); end
        n_checks++; if (sda_io !== 1'b1) begin n_fail++; $display("FAIL reset_sda got %b exp 1", sda_io); end
        for (int i = 0; i < 16; i++) begin
            dbg_read(4'(i), d);
            n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_mem[%0d] got %h exp 00", i, d); end
        end
    endtask

    task automatic test_write();
        logic [7:0] data [$] = '{8'h55, 8'h51, 8'h35, 8'h7D, 8'h77};
        logic [7:0] d;
        logic a;
        int acks = 0;
        strobes.delete();
        i2c_start();
        send_byte(8'h20, a); acks += int'(a);
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL write_busy_after_match got %b exp 1", busy_o); end
        send_byte(8'h00, a); acks += int'(a);
        foreach (data[i]) begin send_byte(data[i], a); acks += int'(a); end
        i2c_stop();
        model_write(8'h00, data);
        n_checks++; if (acks != 7) begin n_fail++; $display("FAIL write_acks got %0d exp 7", acks); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop got %b exp 0", busy_o); end
        n_checks++; if (strobes.size() != 5) begin n_fail++; $display("FAIL write_strobe_count got %0d exp 5", strobes.size()); end
        for (int i = 0; i < 5 && i < strobes.size(); i++) begin
            n_checks++;
            if (strobes[i] !== {4'(i), data[i]}) begin n_fail++; $display("FAIL write_strobe[%0d] got %h exp %h", i, strobes[i], {4'(i), data[i]}); end
        end
        for (int i = 0; i < 5; i++) begin
            dbg_read(4'(i), d);
            n_checks++; if (d !== model_mem[i]) begin n_fail++; $display("FAIL write_mem[%0d] got %h exp %h", i, d, model_mem[i]); end
        end
    endtask

    task automatic test_read();
        logic [7:0] exp [5] = '{8'h55, 8'h51, 8'h35, 8'h7D, 8'h77};
        logic [7:0] b;
        logic a;
        strobes.delete();
        i2c_start();
        send_byte(8'h20, a);
        send_byte(8'h00, a);
        i2c_start();
        send_byte(8'h21, a);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack got %b exp 1", a); end
        for (int i = 0; i < 5; i++) begin
            recv_byte(i < 4, b);
            n_checks++; if (b !== exp[i]) begin n_fail++; $display("FAIL read_byte[%0d] got %h exp %h", i, b, exp[i]); end
        end
        model_ptr = 4'd5;
        #Q;
        n_checks++; if (sda_io !== 1'b1) begin n_fail++; $display("FAIL read_sda_after_nack got %b exp 1", sda_io); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL read_busy_after_nack got %b exp 0", busy_o); end
        i2c_stop();
        n_checks++; if (strobes.size() != 0) begin n_fail++; $display("FAIL read_no_strobe got %0d exp 0", strobes.size()); end
    endtask

    task automatic test_bad_addr();
        logic [7:0] d;
        logic a;
        strobes.delete();
        i2c_start();
        send_byte(8'h40, a);
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL badaddr_ack got %b exp 0", a); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL badaddr_busy got %b exp 0", busy_o); end
        send_byte(8'h01, a);
        send_byte(8'hE7, a);
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL badaddr_data_ack got %b exp 0", a); end
        i2c_stop();
        n_checks++; if (strobes.size() != 0) begin n_fail++; $display("FAIL badaddr_strobe got %0d exp 0", strobes.size()); end
        for (int i = 0; i < 16; i++) begin
            dbg_read(4'(i), d);
            n_checks++; if (d !== model_mem[i]) begin n_fail++; $display("FAIL badaddr_mem[%0d] got %h exp %h", i, d, model_mem[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] data [$] = '{8'hAA, 8'hBB, 8'hCC};
        logic [7:0] d;
        logic a;
        int acks;
        bus_write(8'h0E, data, acks);
        model_write(8'h0E, data);
        n_checks++; if (acks != 5) begin n_fail++; $display("FAIL wrap_acks got %0d exp 5", acks); end
        dbg_read(4'd14, d); n_checks++; if (d !== 8'hAA) begin n_fail++; $display("FAIL wrap_mem14 got %h exp AA", d); end
        dbg_read(4'd15, d); n_checks++; if (d !== 8'hBB) begin n_fail++; $display("FAIL wrap_mem15 got %h exp BB", d); end
        dbg_read(4'd0, d);  n_checks++; if (d !== 8'hCC) begin n_fail++; $display("FAIL wrap_mem0 got %h exp CC", d); end
        // Read without a pointer byte: must start from ptr=1.
        i2c_start();
        send_byte(8'h21, a);
        recv_byte(1'b0, d);
        i2c_stop();
        n_checks++; if (d !== model_mem[1]) begin n_fail++; $display("FAIL wrap_ptr_read got %h exp %h", d, model_mem[1]); end
        model_ptr = 4'd2;
    endtask

    task automatic test_abort();
        logic [7:0] d;
        logic a, r;
        strobes.delete();
        i2c_start();
        send_byte(8'h20, a);
        send_byte(8'h02, a);
        model_ptr = 4'd2;
        bit_xfer(1'b1, r); bit_xfer(1'b0, r); bit_xfer(1'b1, r); bit_xfer(1'b1, r);
        i2c_stop();
        n_checks++; if (strobes.size() != 0) begin n_fail++; $display("FAIL abort_strobe got %0d exp 0", strobes.size()); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy_o); end
        for (int i = 0; i < 16; i++) begin
            dbg_read(4'(i), d);
            n_checks++; if (d !== model_mem[i]) begin n_fail++; $display("FAIL abort_mem[%0d] got %h exp %h", i, d, model_mem[i]); end
        end
        i2c_start();
        send_byte(8'h20, a);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL abort_restart_ack got %b exp 1", a); end
        i2c_stop();
    endtask

    task automatic test_random();
        logic [7:0] data [$];
        logic [7:0] pb, b, d;
        logic [3:0] rp;
        logic a;
        int len, rlen, acks;
        for (int it = 0; it < 6; it++) begin
            pb = 8'($urandom);
            len = $urandom_range(1, 6);
            data.delete();
            for (int i = 0; i < len; i++) data.push_back(8'($urandom));
            strobes.delete();
            bus_write(pb, data, acks);
            n_checks++; if (acks != len + 2) begin n_fail++; $display("FAIL rand%0d_acks got %0d exp %0d", it, acks, len + 2); end
            n_checks++; if (strobes.size() != len) begin n_fail++; $display("FAIL rand%0d_strobes got %0d exp %0d", it, strobes.size(), len); end
            for (int i = 0; i < len && i < strobes.size(); i++) begin
                n_checks++;
                if (strobes[i] !== {4'(pb[3:0] + 4'(i)), data[i]}) begin
                    n_fail++; $display("FAIL rand%0d_strobe[%0d] got %h exp %h", it, i, strobes[i], {4'(pb[3:0] + 4'(i)), data[i]});
                end
            end
            model_write(pb, data);
            rp = 4'($urandom);
            rlen = $urandom_range(1, 6);
            i2c_start();
            send_byte(8'h20, a);
            send_byte({4'($urandom), rp}, a);
            i2c_start();
            send_byte(8'h21, a);
            model_ptr = rp;
            for (int i = 0; i < rlen; i++) begin
                recv_byte(i < rlen - 1, b);
                n_checks++; if (b !== model_mem[model_ptr]) begin n_fail++; $display("FAIL rand%0d_read[%0d] got %h exp %h", it, i, b, model_mem[model_ptr]); end
                model_ptr = model_ptr + 4'd1;
            end
            i2c_stop();
        end
        for (int i = 0; i < 16; i++) begin
            dbg_read(4'(i), d);
            n_checks++; if (d !== model_mem[i]) begin n_fail++; $display("FAIL rand_mem[%0d] got %h exp %h", i, d, model_mem[i]); end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] data [$] = '{8'h12};
        logic [7:0] d;
        logic a;
        int acks;
        bus_write(8'h03, data, acks);
        model_write(8'h03, data);
        i2c_start();
        send_byte(8'h20, a);
        send_byte(8'h03, a);
        i2c_start();
        send_byte(8'h21, a);
        n_checks++; if (sda_io !== 1'b0) begin n_fail++; $display("FAIL rstread_sda_driven got %b exp 0", sda_io); end
        @(posedge pclk_i);
        preset_n_i = 1'b0;
        @(negedge pclk_i);
        n_checks++; if (sda_io !== 1'b1) begin n_fail++; $display("FAIL rstread_sda_released got %b exp 1", sda_io); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstread_busy got %b exp 0", busy_o); end
        scl_m = 1'b1;
        sda_m = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        model_ptr = 4'd0;
        for (int i = 0; i < 16; i++) begin
            dbg_read(4'(i), d);
            n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rstread_mem[%0d] got %h exp 00", i, d); end
        end
        #Q;
        preset_n_i = 1'b1;
        #Q;
        i2c_start();
        send_byte(8'h21, a);
        recv_byte(1'b0, d);
        i2c_stop();
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rstread_after got %h exp 00", d); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_wrap();
        test_abort();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
